// File: rtl/cfg_master_pkg.sv
// -----------------------------------------------------------------------------
// cfg_master_pkg
// Shared definitions for the config bus master: default width constants,
// request op encoding, FSM state encoding and a counter-width helper.
// Optional feature macro: CFG_WRITE_VERIFY_EN adds the VERIFY state.
// -----------------------------------------------------------------------------
package cfg_master_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RD_LATENCY = 0;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } cfg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3
`ifdef CFG_WRITE_VERIFY_EN
        , ST_VERIFY = 3'd4
`endif
    } cfg_state_e;

    // Width of a down-counter that must hold values 0..lat (min 1 bit).
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/cfg_req_fifo.sv
// -----------------------------------------------------------------------------
// cfg_req_fifo
// Synchronous request FIFO. DEPTH must be a power of two (>= 2) so the
// read/write pointers wrap naturally. Flags are derived from registered
// state only, so full/empty never depend combinationally on push/pop.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (flushes FIFO)
//   push, wdata     : write request; ignored while full
//   pop             : advance head; ignored while empty
//   rdata           : current head entry (valid while !empty)
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module cfg_req_fifo
    import cfg_master_pkg::*;
#(
    parameter int WIDTH = 1 + DEF_ADDR_WIDTH + DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/config_bus_master.sv
// -----------------------------------------------------------------------------
// config_bus_master
// Queues config read/write requests and replays them one at a time onto a
// simple downstream config port. Reads return a response; writes do not,
// unless write-verify is built in.
// Optional feature macro: CFG_WRITE_VERIFY_EN -- every write is followed by
// a readback of the same address and a response carrying the readback and a
// mismatch flag on rsp_error. Without it rsp_error is constant 0.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   req_valid/ready/write/addr/data   : request handshake into the FIFO
//   rsp_valid/ready/data/error        : response handshake
//   config_config_addr/data           : downstream address/data (held)
//   config_write, config_read         : downstream strobes (mutually exclusive)
//   read_config_data                  : downstream readback
//   busy                              : work queued or in flight
// -----------------------------------------------------------------------------
module config_bus_master
    import cfg_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] config_config_addr,
    output logic [DATA_WIDTH-1:0] config_config_data,
    output logic                  config_write,
    output logic                  config_read,
    input  logic [DATA_WIDTH-1:0] read_config_data,
    output logic                  busy
);

    localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W = cnt_width(RD_LATENCY);

    // FIFO entry layout: {op, addr, data}
    logic [REQ_W-1:0]      fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    cfg_op_e               head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    cfg_state_e            state;
    cfg_op_e               issue_op;
    logic [CNT_W-1:0]      wait_cnt;

    assign head_op   = cfg_op_e'(fifo_rdata[REQ_W-1]);
    assign head_addr = fifo_rdata[REQ_W-2 -: ADDR_WIDTH];
    assign head_data = fifo_rdata[DATA_WIDTH-1:0];

    // The FSM only drains the FIFO from IDLE, so a stalled response keeps
    // the queue filling until full without losing order.
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    cfg_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid && req_ready),
        .wdata ({req_write, req_addr, req_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef CFG_WRITE_VERIFY_EN
    logic rsp_err_q;
    assign rsp_error = rsp_err_q;
`else
    assign rsp_error = 1'b0;
`endif

    // Strobes are registered: they rise on the IDLE->ISSUE transition so the
    // ISSUE cycle is exactly the first cycle the downstream core sees them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            issue_op           <= OP_READ;
            wait_cnt           <= '0;
            config_write       <= 1'b0;
            config_read        <= 1'b0;
            config_config_addr <= '0;
            config_config_data <= '0;
            rsp_valid          <= 1'b0;
            rsp_data           <= '0;
`ifdef CFG_WRITE_VERIFY_EN
            rsp_err_q          <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        issue_op           <= head_op;
                        config_config_addr <= head_addr;
                        config_config_data <= head_data;
                        config_write       <= (head_op == OP_WRITE);
                        config_read        <= (head_op == OP_READ);
                        state              <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (issue_op == OP_WRITE) begin
                        config_write <= 1'b0;
`ifdef CFG_WRITE_VERIFY_EN
                        // Readback of the just-written address; VERIFY
                        // spans RD_LATENCY+1 cycles like a normal read.
                        config_read <= 1'b1;
                        wait_cnt    <= CNT_W'(RD_LATENCY);
                        state       <= ST_VERIFY;
`else
                        state       <= ST_IDLE;
`endif
                    end else if (RD_LATENCY == 0) begin
                        // Zero latency: ISSUE is also the sampling cycle.
                        config_read <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= read_config_data;
                        state       <= ST_RESP;
                    end else begin
                        // WAIT lasts RD_LATENCY cycles, counting down to 0.
                        wait_cnt <= CNT_W'(RD_LATENCY - 1);
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        config_read <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= read_config_data;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

`ifdef CFG_WRITE_VERIFY_EN
                ST_VERIFY: begin
                    if (wait_cnt == '0) begin
                        // config_config_data still holds the written value.
                        config_read <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= read_config_data;
                        rsp_err_q   <= (read_config_data != config_config_data);
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
`endif

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef CFG_WRITE_VERIFY_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    config_write <= 1'b0;
                    config_read  <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_bus_master.sv
// -----------------------------------------------------------------------------
// tb_config_bus_master
// Two instances: dut_a (RD_LATENCY=0) carries the directed and randomized
// traffic; dut_b (RD_LATENCY=3) covers the latency wait and reset-in-WAIT.
// Each instance talks to a small behavioural core. Random traffic on dut_a
// is scored against a transaction-level model: an in-order queue of expected
// strobes, an in-order queue of expected responses and a shadow memory.
// -----------------------------------------------------------------------------
module tb_config_bus_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

`ifdef CFG_WRITE_VERIFY_EN
    localparam int WR_GAP = 4;
`else
    localparam int WR_GAP = 2;
`endif

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- dut_a signals / core ----------------
    logic        a_req_valid = 0, a_req_write = 0, a_rsp_ready = 0;
    logic [7:0]  a_req_addr = 0;
    logic [31:0] a_req_data = 0;
    logic        a_req_ready, a_rsp_valid, a_rsp_error, a_config_write, a_config_read, a_busy;
    logic [31:0] a_rsp_data, a_config_config_data, a_read_config_data;
    logic [7:0]  a_config_config_addr;

    logic        core_init = 1'b1;
    logic        core_zero = 1'b0;
    logic [31:0] core_a [256];

    always @(posedge clk) begin
        if (core_init) begin
            for (int i = 0; i < 256; i++) core_a[i] <= init_val(i);
        end else if (a_config_write) begin
            core_a[a_config_config_addr] <= a_config_config_data;
        end
    end
    assign a_read_config_data = core_zero ? 32'h0 : core_a[a_config_config_addr];

    config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RD_LATENCY(0)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_data(a_req_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_error(a_rsp_error),
        .config_config_addr(a_config_config_addr), .config_config_data(a_config_config_data),
        .config_write(a_config_write), .config_read(a_config_read),
        .read_config_data(a_read_config_data), .busy(a_busy)
    );

    // ---------------- dut_b signals / core ----------------
    logic        b_req_valid = 0, b_req_write = 0, b_rsp_ready = 1;
    logic [7:0]  b_req_addr = 0;
    logic [31:0] b_req_data = 0;
    logic        b_req_ready, b_rsp_valid, b_rsp_error, b_config_write, b_config_read, b_busy;
    logic [31:0] b_rsp_data, b_config_config_data, b_read_config_data;
    logic [7:0]  b_config_config_addr;

    // Readback changes every cycle so the sampling cycle is observable.
    assign b_read_config_data = {24'hC0FFEE, cyc_cnt[7:0]};

    config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RD_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_data(b_req_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_error(b_rsp_error),
        .config_config_addr(b_config_config_addr), .config_config_data(b_config_config_data),
        .config_write(b_config_write), .config_read(b_config_read),
        .read_config_data(b_read_config_data), .busy(b_busy)
    );

    // ---------------- helpers (called at a negedge) ----------------
    task automatic push_a(input logic wr, input logic [7:0] ad, input logic [31:0] d);
        int n = 0;
        a_req_valid = 1; a_req_write = wr; a_req_addr = ad; a_req_data = d;
        while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("push_a_timeout", 1, 0);
        @(negedge clk);
        a_req_valid = 0;
    endtask

    task automatic push_b(input logic wr, input logic [7:0] ad, input logic [31:0] d);
        int n = 0;
        b_req_valid = 1; b_req_write = wr; b_req_addr = ad; b_req_data = d;
        while (!b_req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("push_b_timeout", 1, 0);
        @(negedge clk);
        b_req_valid = 0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        a_rsp_ready = 1;
        while ((a_busy || a_rsp_valid) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("idle_a_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_ready"}, a_req_ready, 1);
        chk({tag, "_rsp_valid"}, a_rsp_valid, 0);
        chk({tag, "_rsp_error"}, a_rsp_error, 0);
        chk({tag, "_strobes"}, {a_config_write, a_config_read}, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_addr"}, a_config_config_addr, 0);
        chk({tag, "_data"}, a_config_config_data, 0);
        chk({tag, "_rsp_data"}, a_rsp_data, 0);
    endtask

    // ---------------- model for random traffic ----------------
    typedef struct { bit wr; logic [7:0] addr; logic [31:0] data; } strb_t;
    typedef struct { logic [31:0] data; bit err; } rsp_t;
    strb_t       exp_strb[$];
    rsp_t        exp_rsp[$];
    logic [31:0] mdl_mem [256];

    task automatic model_accept(input bit wr, input logic [7:0] ad, input logic [31:0] d);
        if (wr) begin
            exp_strb.push_back('{1'b1, ad, d});
            mdl_mem[ad] = d;
`ifdef CFG_WRITE_VERIFY_EN
            exp_strb.push_back('{1'b0, ad, 32'h0});
            exp_rsp.push_back('{d, 1'b0});
`endif
        end else begin
            exp_strb.push_back('{1'b0, ad, 32'h0});
            exp_rsp.push_back('{mdl_mem[ad], 1'b0});
        end
    endtask

    task automatic observe_strobes();
        strb_t e;
        if (a_config_write && a_config_read) chk("rnd_strobe_excl", 1, 0);
        if (a_config_write || a_config_read) begin
            if (exp_strb.size() == 0) chk("rnd_strobe_unexpected", 1, 0);
            else begin
                e = exp_strb.pop_front();
                chk("rnd_strobe_kind", a_config_write, e.wr);
                chk("rnd_strobe_addr", a_config_config_addr, e.addr);
                if (e.wr) chk("rnd_strobe_data", a_config_config_data, e.data);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int pushed, strobes, last, n_hi, first_hi, got_rsp, bad;
        bit full_seen, stalled;
        logic [31:0] last_rd, stalled_data;
        rsp_t r;

        repeat (3) @(negedge clk);
        core_init = 0;
        reset = 0;
        @(negedge clk);
        chk_reset_a("rst");

        // Single write: strobe exactly 2 cycles after the accept cycle.
        a_rsp_ready = 1;
        push_a(1, 8'h01, 32'hDEADBEEF);
        chk("wr_n1_strobe", a_config_write, 0);
        @(negedge clk);
        chk("wr_n2_strobe", a_config_write, 1);
        chk("wr_n2_addr", a_config_config_addr, 8'h01);
        chk("wr_n2_data", a_config_config_data, 32'hDEADBEEF);
        chk("wr_n2_no_read", a_config_read, 0);
        @(negedge clk);
        chk("wr_n3_strobe", a_config_write, 0);
        chk("wr_hold_addr", a_config_config_addr, 8'h01);
        chk("wr_hold_data", a_config_config_data, 32'hDEADBEEF);
`ifdef CFG_WRITE_VERIFY_EN
        chk("wrv_readback", a_config_read, 1);
        @(negedge clk);
        chk("wrv_rsp_valid", a_rsp_valid, 1);
        chk("wrv_rsp_data", a_rsp_data, 32'hDEADBEEF);
        chk("wrv_rsp_err", a_rsp_error, 0);
`else
        bad = 0;
        repeat (6) begin @(negedge clk); bad |= int'(a_rsp_valid); end
        chk("wr_no_rsp", bad, 0);
`endif
        wait_idle_a();

        // Read addr 1 (core holds DEADBEEF), then stall the response.
        a_rsp_ready = 0;
        push_a(0, 8'h01, 32'h0);
        chk("rd_n1_read", a_config_read, 0);
        @(negedge clk);
        chk("rd_n2_read", a_config_read, 1);
        chk("rd_n2_addr", a_config_config_addr, 8'h01);
        @(negedge clk);
        chk("rd_n3_read", a_config_read, 0);
        chk("rd_rsp_valid", a_rsp_valid, 1);
        chk("rd_rsp_data", a_rsp_data, 32'hDEADBEEF);
        push_a(1, 8'h02, 32'h0000_2222);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!a_rsp_valid || a_rsp_data !== 32'hDEADBEEF || a_config_write || a_config_read) bad++;
        end
        chk("stall_stable", bad, 0);
        a_rsp_ready = 1;
        @(negedge clk);
        chk("stall_release_valid", a_rsp_valid, 0);
        chk("stall_release_nowr", a_config_write, 0);
        @(negedge clk);
        chk("stall_next_wr", a_config_write, 1);
        chk("stall_next_addr", a_config_config_addr, 8'h02);
        wait_idle_a();

        // FIFO fill: stall FSM in RESP, queue 5 writes.
        a_rsp_ready = 0;
        push_a(0, 8'h03, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("fill_rsp_valid", a_rsp_valid, 1);
        pushed = 0; strobes = 0; last = -100; full_seen = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (pushed < 5) begin
                a_req_valid = 1; a_req_write = 1;
                a_req_addr = 8'h10 + 8'(pushed); a_req_data = 32'h1000 + 32'(pushed);
            end else a_req_valid = 0;
            if (cyc == 6) begin
                chk("fill_rsp_data", a_rsp_data, init_val(3));
                a_rsp_ready = 1;
            end
            if (a_req_valid && a_req_ready) pushed++;
            @(negedge clk);
            if (pushed == 4 && !full_seen) begin
                chk("fill_ready_low", a_req_ready, 0);
                full_seen = 1;
            end
            if (a_config_write) begin
                chk("fill_order", a_config_config_addr, 8'h10 + 8'(strobes));
                if (strobes > 0) chk("fill_gap", cyc - last, WR_GAP);
                last = cyc;
                strobes++;
            end
        end
        a_req_valid = 0;
        chk("fill_count", strobes, 5);
        wait_idle_a();

`ifdef CFG_WRITE_VERIFY_EN
        // Write-verify against a core that reads back zero.
        core_zero = 1;
        a_rsp_ready = 1;
        push_a(1, 8'h20, 32'h5A);
        @(negedge clk);
        chk("vfy_write", a_config_write, 1);
        @(negedge clk);
        chk("vfy_read", a_config_read, 1);
        chk("vfy_read_addr", a_config_config_addr, 8'h20);
        @(negedge clk);
        chk("vfy_rsp_valid", a_rsp_valid, 1);
        chk("vfy_rsp_data", a_rsp_data, 32'h0);
        chk("vfy_rsp_err", a_rsp_error, 1);
        core_zero = 0;
        wait_idle_a();
`endif

        // dut_b: RD_LATENCY=3 read; data sampled in last config_read cycle.
        push_b(0, 8'h05, 32'h0);
        n_hi = 0; first_hi = -1; got_rsp = 0; last_rd = '0;
        for (int i = 1; i <= 12; i++) begin
            if (b_config_read) begin
                n_hi++;
                if (first_hi < 0) first_hi = i;
                last_rd = b_read_config_data;
                chk("b_rd_addr", b_config_config_addr, 8'h05);
            end
            if (b_rsp_valid) begin
                got_rsp++;
                chk("b_rsp_data", b_rsp_data, last_rd);
            end
            @(negedge clk);
        end
        chk("b_first_read", first_hi, 2);
        chk("b_read_len", n_hi, 4);
        chk("b_rsp_count", got_rsp, 1);

        // Reset during WAIT discards current read and queued write.
        push_b(0, 8'h06, 32'h0);
        push_b(1, 8'h07, 32'h77);
        chk("b_issue_read", b_config_read, 1);
        @(negedge clk);
        chk("b_wait_read", b_config_read, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("b_rst_read", b_config_read, 0);
        chk("b_rst_busy", b_busy, 0);
        chk("b_rst_rsp", b_rsp_valid, 0);
        chk("b_rst_ready", b_req_ready, 1);
        chk_reset_a("rst2");
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            bad |= int'(b_config_read | b_config_write | b_rsp_valid | b_busy);
        end
        chk("b_after_rst_quiet", bad, 0);

        // Randomized traffic on dut_a against the transaction model.
        core_init = 1;
        for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
        @(negedge clk);
        core_init = 0;
        stalled = 0; stalled_data = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            a_req_valid = ($urandom_range(0, 1) == 1);
            a_req_write = ($urandom_range(0, 1) == 1);
            a_req_addr  = 8'($urandom_range(0, 7));
            a_req_data  = $urandom;
            a_rsp_ready = ($urandom_range(0, 9) < 7);
            if (a_req_valid && a_req_ready) model_accept(a_req_write, a_req_addr, a_req_data);
            if (a_rsp_valid && a_rsp_ready) begin
                if (exp_rsp.size() == 0) chk("rnd_rsp_unexpected", 1, 0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("rnd_rsp_data", a_rsp_data, r.data);
                    chk("rnd_rsp_err", a_rsp_error, r.err);
                end
            end
            stalled = a_rsp_valid && !a_rsp_ready;
            stalled_data = a_rsp_data;
            @(negedge clk);
            if (stalled) begin
                chk("rnd_rsp_hold_valid", a_rsp_valid, 1);
                chk("rnd_rsp_hold_data", a_rsp_data, stalled_data);
            end
            observe_strobes();
        end
        a_req_valid = 0;
        a_rsp_ready = 1;
        for (int n = 0; n < 200 && (a_busy || a_rsp_valid || exp_strb.size() != 0); n++) begin
            if (a_rsp_valid) begin
                if (exp_rsp.size() == 0) chk("drain_rsp_unexpected", 1, 0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("drain_rsp_data", a_rsp_data, r.data);
                    chk("drain_rsp_err", a_rsp_error, r.err);
                end
            end
            @(negedge clk);
            observe_strobes();
        end
        chk("drain_strb_left", exp_strb.size(), 0);
        chk("drain_rsp_left", exp_rsp.size(), 0);
        chk("drain_busy", a_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_bus_master.md
CONFIG_BUS_MASTER -- requirements
Module: config_bus_master

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- ADDR_WIDTH, 8, config address width.
- DATA_WIDTH, 32, config data width.
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.
- RD_LATENCY, 0, cycles from first config_read cycle to the cycle in which read_config_data is sampled.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, sole clock; all state on its rising edge.
- reset, in, 1, synchronous active-high reset.
- req_valid, in, 1, request offered.
- req_ready, out, 1, request FIFO not full.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_WIDTH, target config address.
- req_data, in, DATA_WIDTH, write data; ignored for reads.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_data, out, DATA_WIDTH, read data.
- rsp_error, out, 1, verify mismatch.
- config_config_addr, out, ADDR_WIDTH, downstream core config address.
- config_config_data, out, DATA_WIDTH, downstream core config data.
- config_write, out, 1, write strobe.
- config_read, out, 1, read enable.
- read_config_data, in, DATA_WIDTH, readback from core.
- busy, out, 1, FIFO non-empty or FSM not IDLE.

Function
REQ-003 Request SHALL be accepted iff req_valid && req_ready; req_ready = !fifo_full, registered, with no bypass of a full FIFO.
REQ-004 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; plus VERIFY when CFG_WRITE_VERIFY_EN is defined.
REQ-005 IDLE: if FIFO non-empty, pop the head into issue registers -> ISSUE; else stay in IDLE.
REQ-006 ISSUE (one cycle): drive addr/data from issue registers; write -> config_write=1 -> IDLE; read -> config_read=1 -> RESP if RD_LATENCY==0, else WAIT.
REQ-007 WAIT: hold config_read=1 and addr stable for RD_LATENCY further cycles; sample read_config_data in the last such cycle -> RESP.
REQ-008 Read data SHALL be captured in the sampling cycle; with RD_LATENCY=0 the sampling cycle is the ISSUE cycle.
REQ-009 RESP: rsp_valid=1 with rsp_data stable until rsp_ready; -> IDLE on the cycle of handshake.
REQ-010 A request accepted at cycle N with an empty FIFO and FSM in IDLE SHALL strobe at N+2; back-to-back writes SHALL strobe every 2nd cycle.
REQ-011 config_write and config_read SHALL never be asserted in the same cycle; both SHALL be 0 outside ISSUE, WAIT and VERIFY.
REQ-012 config_config_addr/data SHALL hold the last issued values between transactions.
REQ-013 Writes SHALL produce no response unless CFG_WRITE_VERIFY_EN is defined.
REQ-014 FIFO SHALL remain open while a response is stalled: pushes continue until full, and pops resume after RESP completes.

Reset
REQ-015 On reset: FSM=IDLE, FIFO flushed, req_ready=1 in the following cycle; rsp_valid, rsp_error, config_write, config_read, busy = 0; config_config_addr/data and rsp_data = 0.
REQ-016 Reset mid-transaction SHALL abort it: strobes drop in the next cycle, and any pending response and queued requests are discarded.

Configuration
REQ-017 With CFG_WRITE_VERIFY_EN defined, after a write ISSUE the FSM SHALL go to VERIFY: config_read=1 on the same address, with the RD_LATENCY wait applied.
REQ-018 In VERIFY, the sampled data SHALL be compared against the written data, then -> RESP with rsp_data = readback and rsp_error = mismatch.
REQ-019 Without CFG_WRITE_VERIFY_EN, rsp_error SHALL be tied to 0 and no VERIFY state SHALL exist.

Structure
REQ-020 Package cfg_master_pkg SHALL hold the FSM state enum, the op encoding (OP_READ=0, OP_WRITE=1), and the default width constants.
REQ-021 Request storage SHALL be a sub-module cfg_req_fifo (synchronous, full/empty flags, pointer wrap at FIFO_DEPTH); the FSM lives in config_bus_master.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Write addr 0x01 data 0xDEADBEEF -> one config_write pulse 2 cycles after accept with addr=0x01, data=0xDEADBEEF; no rsp_valid.
- Read addr 0x01 with core returning 0xDEADBEEF, RD_LATENCY=0 -> config_read high for 1 cycle; rsp_valid with rsp_data=0xDEADBEEF.
- Push 5 writes with rsp_ready=1 and FIFO_DEPTH=4 while the FSM is busy -> req_ready=0 after the 4th queued entry; all 5 writes issued in order, one every 2 cycles.
- Read with rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable throughout; next request not issued until handshake.
- Assert reset during WAIT with RD_LATENCY=3 -> config_read=0 next cycle, busy=0, no response.
- CFG_WRITE_VERIFY_EN: write 0x5A to a core whose readback returns 0x00 -> config_write, then config_read, then rsp_valid with rsp_data=0x00 and rsp_error=1.
